spi_square_top: RTL and testbench

- Top-level SPI driver for an ILI9341-class TFT display.
- After reset it performs the following in order: hardware reset of the panel, minimal init sequence, WIDTH×HEIGHT address window, then streams a solid-colour square.
- Sits directly on FPGA pins: one system clock in, SPI/control lines out, LED as completion indicator.

---
 rtl/spi_square_top.sv | 188 ++++++++++++++++++
 tb/tb_spi_square_top.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_square_top.sv
// ILI9341-class TFT bring-up and solid square fill over SPI mode 0.
// Panel reset, init commands, address window, then COLOR pixel stream.
module spi_square_top #(
  parameter int          DELAY  = 2_000_000,
  parameter int          WIDTH  = 240,
  parameter int          HEIGHT = 320,
  parameter logic [15:0] COLOR  = 16'hF800
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_mosi,
  output logic o_cs,
  output logic o_dc,
  output logic o_rst,
  output logic o_clk,
  output logic o_led
);

  typedef enum logic [3:0] {
    RST_LOW, RST_WAIT, SLPOUT, SLP_WAIT,
    COLMOD, MADCTL, DISPON, CASET,
    PASET, RAMWR, PIXELS, DONE
  } state_t;

  localparam int          DW    = $clog2(DELAY + 1);
  localparam logic [DW-1:0] DLAST = DW'(DELAY - 1);
  localparam logic [16:0] PLAST = 17'(WIDTH * HEIGHT - 1);
  localparam logic [15:0] WLAST = 16'(WIDTH - 1);
  localparam logic [15:0] HLAST = 16'(HEIGHT - 1);

  state_t        state, state_n;
  logic [2:0]    idx, idx_n, last;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [16:0]   pix, pix_n;

  logic       busy;
  logic [4:0] cnt;
  logic [7:0] sr;
  logic       tx_done, start, send, tx_dc;
  logic [7:0] tx_byte;

  assign tx_done = busy && (cnt == 5'd16);

  // Sequencer next state: timed waits, per-state byte index, pixel count
  always_comb begin
    state_n = state;
    idx_n   = idx;
    dcnt_n  = dcnt;
    pix_n   = pix;
    last    = 3'd0;
    case (state)
      COLMOD, MADCTL: last = 3'd1;
      CASET, PASET:   last = 3'd4;
      default:        last = 3'd0;
    endcase
    case (state)
      RST_LOW, RST_WAIT, SLP_WAIT: begin
        if (dcnt == DLAST) begin
          dcnt_n = '0;
          case (state)
            RST_LOW:  state_n = RST_WAIT;
            RST_WAIT: state_n = SLPOUT;
            default:  state_n = COLMOD;
          endcase
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      SLPOUT, COLMOD, MADCTL, DISPON,
      CASET, PASET, RAMWR: begin
        if (tx_done) begin
          if (idx == last) begin
            idx_n = 3'd0;
            case (state)
              SLPOUT:  state_n = SLP_WAIT;
              COLMOD:  state_n = MADCTL;
              MADCTL:  state_n = DISPON;
              DISPON:  state_n = CASET;
              CASET:   state_n = PASET;
              PASET:   state_n = RAMWR;
              default: state_n = PIXELS;
            endcase
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      PIXELS: begin
        if (tx_done) begin
          if (idx[0]) begin
            idx_n = 3'd0;
            if (pix == PLAST) state_n = DONE;
            else              pix_n   = pix + 17'd1;
          end else begin
            idx_n = 3'd1;
          end
        end
      end
      default: state_n = DONE;
    endcase
  end

  // Byte for the upcoming slot; launching from the next state lets a
  // byte start on the same edge that ends a wait
  always_comb begin
    tx_byte = 8'h00;
    tx_dc   = (idx_n != 3'd0);
    send    = 1'b1;
    case (state_n)
      SLPOUT: tx_byte = 8'h11;
      COLMOD: tx_byte = (idx_n == 3'd0) ? 8'h3A : 8'h55;
      MADCTL: tx_byte = (idx_n == 3'd0) ? 8'h36 : 8'h48;
      DISPON: tx_byte = 8'h29;
      CASET, PASET: begin
        case (idx_n)
          3'd0:    tx_byte = (state_n == CASET) ? 8'h2A : 8'h2B;
          3'd3:    tx_byte = (state_n == CASET) ? WLAST[15:8] : HLAST[15:8];
          3'd4:    tx_byte = (state_n == CASET) ? WLAST[7:0] : HLAST[7:0];
          default: tx_byte = 8'h00;
        endcase
      end
      RAMWR: tx_byte = 8'h2C;
      PIXELS: begin
        tx_byte = idx_n[0] ? COLOR[7:0] : COLOR[15:8];
        tx_dc   = 1'b1;
      end
      default: send = 1'b0;
    endcase
  end

  assign start = send && !busy;

  // Sequencer registers plus panel reset and completion flags
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= RST_LOW;
      idx   <= 3'd0;
      dcnt  <= '0;
      pix   <= 17'd0;
      o_rst <= 1'b0;
      o_led <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      dcnt  <= dcnt_n;
      pix   <= pix_n;
      o_rst <= (state_n != RST_LOW);
      o_led <= (state_n == DONE);
    end
  end

  // Byte shifter: 16 half-bit cycles then one cs-high cycle
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      busy   <= 1'b0;
      cnt    <= 5'd0;
      sr     <= 8'h00;
      o_cs   <= 1'b1;
      o_clk  <= 1'b0;
      o_mosi <= 1'b0;
      o_dc   <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= 5'd1;
      sr     <= {tx_byte[6:0], 1'b0};
      o_mosi <= tx_byte[7];
      o_dc   <= tx_dc;
      o_cs   <= 1'b0;
      o_clk  <= 1'b0;
    end else if (busy) begin
      if (cnt == 5'd16) begin
        busy  <= 1'b0;
        cnt   <= 5'd0;
        o_cs  <= 1'b1;
        o_clk <= 1'b0;
      end else if (cnt[0]) begin
        o_clk <= 1'b1;
        cnt   <= cnt + 5'd1;
      end else begin
        o_clk  <= 1'b0;
        o_mosi <= sr[7];
        sr     <= {sr[6:0], 1'b0};
        cnt    <= cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_square_top.sv
// Bench for spi_square_top: decodes the SPI stream and compares it with
// a byte list built from the panel command set.
module tb_spi_square_top;

  localparam int DELAY  = 20;
  localparam int WIDTH  = 24;
  localparam int HEIGHT = 32;
  localparam logic [15:0] COLOR = 16'hF800;

  logic clk = 1'b0;
  logic i_rst = 1'b0;
  logic o_mosi, o_cs, o_dc, o_rst, o_clk, o_led;

  int total = 0;
  int bad = 0;
  int tviol = 0;

  logic [8:0] rx[$];
  logic [8:0] expq[$];

  spi_square_top #(
    .DELAY(DELAY), .WIDTH(WIDTH),
    .HEIGHT(HEIGHT), .COLOR(COLOR)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .o_mosi(o_mosi), .o_cs(o_cs),
    .o_dc(o_dc), .o_rst(o_rst),
    .o_clk(o_clk), .o_led(o_led)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic chk_stream(input string tag);
    int nb, first;
    nb = 0;
    first = -1;
    chk({tag, "_len"}, rx.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i >= rx.size() || rx[i] !== expq[i]) begin
        nb++;
        if (first < 0) first = i;
      end
    end
    chk({tag, "_bytes_bad"}, nb, 0);
    if (first >= 0 && first < rx.size())
      chk({tag, "_first_bad"}, int'(rx[first]), int'(expq[first]));
  endtask

  task automatic wait_led(input string tag);
    int n;
    n = 0;
    while (o_led !== 1'b1 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_led_timeout"}, int'(n < 40000), 1);
  endtask

  // Line monitor: byte decode on o_clk rises plus timing rule checks
  initial begin
    logic pclk, pmosi, pcs, dc0;
    logic [7:0] sh;
    int bits, nb, gap;
    pclk = 0; pmosi = 0; pcs = 1; dc0 = 0;
    sh = 0; bits = 0; nb = 0; gap = 0;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        pclk = 0; pmosi = 0; pcs = 1;
        bits = 0; nb = 0; gap = 0;
      end else begin
        if (o_cs && o_clk) tviol++;
        if (!o_cs && pcs) begin
          if (nb > 0 && gap != ((nb == 1) ? DELAY : 1)) tviol++;
          bits = 0;
          dc0 = o_dc;
        end
        if (!o_cs && o_dc !== dc0) tviol++;
        if (o_clk && pclk) tviol++;
        if (!o_cs && !pcs && !o_clk && !pclk) tviol++;
        if (o_clk && o_mosi !== pmosi) tviol++;
        if (o_clk && !pclk && !o_cs) begin
          sh = {sh[6:0], o_mosi};
          bits++;
          if (bits == 8) rx.push_back({dc0, sh});
        end
        if (o_cs && !pcs) begin
          if (bits != 8) tviol++;
          nb++;
          gap = 0;
        end
        if (o_cs) gap++;
        pclk = o_clk;
        pmosi = o_mosi;
        pcs = o_cs;
      end
    end
  end

  initial begin
    int n, m, k, rises, hold, badl;
    logic [15:0] wl, hl;
    logic pc;

    wl = 16'(WIDTH - 1);
    hl = 16'(HEIGHT - 1);
    expq = '{9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029};
    expq.push_back(9'h02A);
    expq.push_back(9'h100);
    expq.push_back(9'h100);
    expq.push_back({1'b1, wl[15:8]});
    expq.push_back({1'b1, wl[7:0]});
    expq.push_back(9'h02B);
    expq.push_back(9'h100);
    expq.push_back(9'h100);
    expq.push_back({1'b1, hl[15:8]});
    expq.push_back({1'b1, hl[7:0]});
    expq.push_back(9'h02C);
    for (int p = 0; p < WIDTH * HEIGHT; p++) begin
      expq.push_back({1'b1, COLOR[15:8]});
      expq.push_back({1'b1, COLOR[7:0]});
    end

    repeat (5) @(negedge clk);
    chk("rst_cs", o_cs, 1);
    chk("rst_clk", o_clk, 0);
    chk("rst_mosi", o_mosi, 0);
    chk("rst_dc", o_dc, 0);
    chk("rst_panel", o_rst, 0);
    chk("rst_led", o_led, 0);

    i_rst = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (o_rst !== 1'b1 && n < 1000);
    chk("panel_rst_low_len", n, DELAY);
    m = 0;
    do begin
      @(posedge clk); #1;
      m++;
    end while (o_cs !== 1'b0 && m < 1000);
    chk("first_cs_delay", m, DELAY);
    chk("first_dc", o_dc, 0);

    wait_led("run1");
    chk_stream("run1");
    chk("run1_first", int'(rx[0]), 9'h011);
    chk("done_cs", o_cs, 1);
    chk("done_clk", o_clk, 0);
    chk("run1_timing_viol", tviol, 0);

    rises = 0;
    pc = o_clk;
    repeat (10000) begin
      @(negedge clk);
      if (o_clk && !pc) rises++;
      pc = o_clk;
    end
    chk("done_quiet_clk", rises, 0);
    chk("done_led_hold", o_led, 1);

    i_rst = 1'b0;
    @(negedge clk);
    rx.delete();
    i_rst = 1'b1;
    k = 17 + $urandom_range(0, 2 * WIDTH * HEIGHT - 8);
    n = 0;
    while (rx.size() < k && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach_timeout", int'(n < 40000), 1);
    repeat ($urandom_range(0, 16)) @(negedge clk);
    @(posedge clk); #2;
    i_rst = 1'b0;
    #1;
    chk("mid_cs", o_cs, 1);
    chk("mid_clk", o_clk, 0);
    chk("mid_mosi", o_mosi, 0);
    chk("mid_dc", o_dc, 0);
    chk("mid_panel", o_rst, 0);
    chk("mid_led", o_led, 0);
    repeat (3) @(negedge clk);
    rx.delete();
    tviol = 0;
    i_rst = 1'b1;
    wait_led("run2");
    chk_stream("run2");
    chk("run2_timing_viol", tviol, 0);

    i_rst = 1'b0;
    rx.delete();
    hold = $urandom_range(200, 500);
    badl = 0;
    repeat (hold) begin
      @(negedge clk);
      if (o_cs !== 1'b1 || o_clk !== 1'b0 || o_rst !== 1'b0 || o_led !== 1'b0)
        badl++;
    end
    chk("long_rst_bad_cycles", badl, 0);
    chk("long_rst_traffic", rx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
